// File: rtl/alu_result_stage.sv
// Result stage behind the 32-bit ALU: buffers results in a small FIFO,
// tracks the architectural condition codes, sticky overflow and a retired count.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_y,
    input  logic [2:0]       in_op,
    input  logic             in_n,
    input  logic             in_z,
    input  logic             in_c,
    input  logic             in_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [2:0]       out_op,
    output logic [3:0]       out_flags,
    output logic [3:0]       ccr,
    input  logic [3:0]       cond_sel,
    output logic             cond_true,
    output logic             sticky_o,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0] mem_y    [DEPTH];
    logic [2:0]  mem_op   [DEPTH];
    logic [3:0]  mem_flag [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic push;
    logic pop;
    logic arith_op;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign arith_op  = (in_op <= 3'd2);

    assign out_y     = mem_y[rd_ptr];
    assign out_op    = mem_op[rd_ptr];
    assign out_flags = mem_flag[rd_ptr];

    // FIFO storage and pointers; storage is cleared on reset so the head never shows X
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_y[i]    <= '0;
                mem_op[i]   <= '0;
                mem_flag[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_y[wr_ptr]    <= in_y;
                mem_op[wr_ptr]   <= in_op;
                mem_flag[wr_ptr] <= {in_n, in_z, in_c, in_o};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Logical ops only refresh N/Z; carry and overflow keep their last arithmetic values
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr      <= '0;
            sticky_o <= 1'b0;
            retired  <= '0;
        end else begin
            if (push) begin
                case (in_op)
                    3'b000, 3'b001, 3'b010: ccr <= {in_n, in_z, in_c, in_o};
                    3'b011, 3'b100, 3'b101, 3'b110: ccr[3:2] <= {in_n, in_z};
                    default: ;
                endcase
            end
            if (push && arith_op && in_o) begin
                sticky_o <= 1'b1;
            end else if (sticky_clr) begin
                sticky_o <= 1'b0;
            end
            if (pop && (retired != {CNT_W{1'b1}})) begin
                retired <= retired + 1'b1;
            end
        end
    end

    logic fn, fz, fc, fo;
    assign {fn, fz, fc, fo} = ccr;

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            4'd0:  cond_true = fz;
            4'd1:  cond_true = !fz;
            4'd2:  cond_true = fc;
            4'd3:  cond_true = !fc;
            4'd4:  cond_true = fn;
            4'd5:  cond_true = !fn;
            4'd6:  cond_true = fo;
            4'd7:  cond_true = !fo;
            4'd8:  cond_true = fc & !fz;
            4'd9:  cond_true = !fc | fz;
            4'd10: cond_true = (fn == fo);
            4'd11: cond_true = (fn != fo);
            4'd12: cond_true = !fz & (fn == fo);
            4'd13: cond_true = fz | (fn != fo);
            4'd14: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
